// File: rtl/reg_write_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
package reg_arb_pkg;

    localparam int unsigned DEF_NREQ      = 3;
    localparam int unsigned DEF_DW        = 16;
    localparam int unsigned DEF_AW        = 2;
    localparam int unsigned DEF_MAX_BURST = 4;

    // Ceiling log2, usable in constant expressions.
    function automatic int unsigned clog2_u(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Index width for owner/ptr (up to 4 requesters).
    localparam int unsigned IW = clog2_u(4);
    // Burst counter width (MAX_BURST up to 15).
    localparam int unsigned CW = clog2_u(16);

    typedef enum logic {ST_IDLE, ST_LOCKED} arb_state_t;

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Requester-side handshake and register-block write port of the arbiter.
interface reg_write_arbiter_if
    import reg_arb_pkg::*;
#(
    parameter int unsigned NREQ = DEF_NREQ,
    parameter int unsigned DW   = DEF_DW,
    parameter int unsigned AW   = DEF_AW
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_lock;
    logic [NREQ*AW-1:0] req_wn;
    logic [NREQ*DW-1:0] req_wd;
    logic [NREQ-1:0]    req_ready;
    logic               w;
    logic [AW-1:0]      wn;
    logic [DW-1:0]      wd;
    logic [IW-1:0]      owner;
    logic               locked;

    modport master (
        output req_valid, req_lock, req_wn, req_wd,
        input  req_ready, w, wn, wd, owner, locked
    );

    modport slave (
        input  req_valid, req_lock, req_wn, req_wd,
        output req_ready, w, wn, wd, owner, locked
    );
endinterface

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational rotating-priority encoder: first set bit at or above ptr, wrapping.
module rr_pick
    import reg_arb_pkg::*;
#(
    parameter int unsigned NREQ = DEF_NREQ
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);
    // Scan NREQ positions starting at ptr; keep the first hit.
    always_comb begin
        int unsigned j;
        logic [IW-1:0] jj;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        jj  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            j  = (32'(ptr) + k) % NREQ;
            jj = IW'(j);
            if (!any && req[jj]) begin
                gnt[jj] = 1'b1;
                idx     = jj;
                any     = 1'b1;
            end
        end
    end
endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter with bounded lock bursts in front of the register-block write port.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int unsigned NREQ      = DEF_NREQ,
    parameter int unsigned DW        = DEF_DW,
    parameter int unsigned AW        = DEF_AW,
    parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
    input logic                clk,
    input logic                rst,
    reg_write_arbiter_if.slave bus
);
    arb_state_t      state;
    logic [IW-1:0]   ptr;
    logic [CW-1:0]   burst_cnt;
    logic [IW-1:0]   owner_q;
    logic            w_q;
    logic [AW-1:0]   wn_q;
    logic [DW-1:0]   wd_q;

    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic [NREQ-1:0] ready;
    logic [IW-1:0]   gnt_idx;
    logic            gnt_any;
    logic [AW-1:0]   sel_wn;
    logic [DW-1:0]   sel_wd;
    logic [IW-1:0]   next_ptr;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req (bus.req_valid),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Grant: round-robin pick when idle, only the holder when locked; forced low in reset.
    always_comb begin
        ready = '0;
        if (rst) begin
            if (state == ST_IDLE) begin
                ready = pick_gnt;
            end else if (bus.req_valid[owner_q]) begin
                ready[owner_q] = 1'b1;
            end
        end
    end

    assign gnt_idx  = (state == ST_IDLE) ? pick_idx : owner_q;
    assign gnt_any  = |ready;
    assign next_ptr = (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;

    // Route the granted requester's address and data to the write registers.
    always_comb begin
        sel_wn = '0;
        sel_wd = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_idx == IW'(i)) begin
                sel_wn = bus.req_wn[i*AW +: AW];
                sel_wd = bus.req_wd[i*DW +: DW];
            end
        end
    end

    // Arbitration FSM, burst counting and registered write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            burst_cnt <= '0;
            owner_q   <= '0;
            w_q       <= 1'b0;
            wn_q      <= '0;
            wd_q      <= '0;
        end else begin
            w_q <= gnt_any;
            if (gnt_any) begin
                wn_q <= sel_wn;
                wd_q <= sel_wd;
            end
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        owner_q <= pick_idx;
                        ptr     <= next_ptr;
                        if (bus.req_lock[pick_idx] && (MAX_BURST > 1)) begin
                            state     <= ST_LOCKED;
                            burst_cnt <= CW'(1);
                        end
                    end
                end
                ST_LOCKED: begin
                    // ptr already points past the holder, so a release hands priority onward.
                    if (gnt_any) begin
                        burst_cnt <= burst_cnt + 1'b1;
                        if (!(bus.req_lock[owner_q] && ((32'(burst_cnt) + 1) < MAX_BURST))) begin
                            state     <= ST_IDLE;
                            burst_cnt <= '0;
                        end
                    end else begin
                        state     <= ST_IDLE;
                        burst_cnt <= '0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    burst_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.req_ready = ready;
    assign bus.w         = w_q;
    assign bus.wn        = wn_q;
    assign bus.wd        = wd_q;
    assign bus.owner     = owner_q;
    assign bus.locked    = (state == ST_LOCKED);

endmodule
